// File: rtl/sample_scheduler.sv
// Sample scheduler: walks a latched triangle's bounding box on a
// sub-pixel lattice, one sample per unstalled cycle, row-major from lower-left.
module sample_scheduler #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS-1:0][AXIS-1:0],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS-1:0],
  input  logic signed [SIGFIG-1:0] box_R13S [1:0][1:0],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     stall_R14H,
  output logic                     halt_RnnnnH,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS-1:0][AXIS-1:0],
  output logic        [SIGFIG-1:0] color_R14U [COLORS-1:0],
  output logic signed [SIGFIG-1:0] sample_R14S [1:0],
  output logic                     validSamp_R14H
);

  localparam int W = SIGFIG + 1;

  typedef logic signed [W-1:0] wide_t;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic signed [SIGFIG-1:0] tri_q [VERTS-1:0][AXIS-1:0];
  logic signed [SIGFIG-1:0] tri_d [VERTS-1:0][AXIS-1:0];
  logic        [SIGFIG-1:0] color_q [COLORS-1:0];
  logic        [SIGFIG-1:0] color_d [COLORS-1:0];
  logic signed [SIGFIG-1:0] ll_q [1:0];
  logic signed [SIGFIG-1:0] ll_d [1:0];
  logic signed [SIGFIG-1:0] ur_q [1:0];
  logic signed [SIGFIG-1:0] ur_d [1:0];
  logic signed [SIGFIG-1:0] samp_q [1:0];
  logic signed [SIGFIG-1:0] samp_d [1:0];
  wide_t                    step_q, step_d;
  wide_t                    step_in;

  wide_t x_sum, y_sum;
  logic  x_fit, y_fit;
  logic  box_empty;

  function automatic wide_t ext(input logic signed [SIGFIG-1:0] v);
    return {v[SIGFIG-1], v};
  endfunction

  always_comb begin
    case (subSample_RnnnnU)
      4'b0100: step_in = wide_t'(2 ** (RADIX - 1));
      4'b0010: step_in = wide_t'(2 ** (RADIX - 2));
      4'b0001: step_in = wide_t'(2 ** (RADIX - 3));
      default: step_in = wide_t'(2 ** RADIX);
    endcase
  end

  // One extra bit keeps the lattice step compare exact at range extremes
  assign x_sum = ext(samp_q[0]) + step_q;
  assign y_sum = ext(samp_q[1]) + step_q;
  assign x_fit = x_sum <= ext(ur_q[0]);
  assign y_fit = y_sum <= ext(ur_q[1]);

  assign box_empty = (box_R13S[1][0] < box_R13S[0][0]) ||
                     (box_R13S[1][1] < box_R13S[0][1]);

  always_comb begin
    state_d = state_q;
    tri_d   = tri_q;
    color_d = color_q;
    ll_d    = ll_q;
    ur_d    = ur_q;
    step_d  = step_q;
    samp_d  = samp_q;
    unique case (state_q)
      WAIT: begin
        if (validTri_R13H && !box_empty) begin
          tri_d     = tri_R13S;
          color_d   = color_R13U;
          ll_d[0]   = box_R13S[0][0];
          ll_d[1]   = box_R13S[0][1];
          ur_d[0]   = box_R13S[1][0];
          ur_d[1]   = box_R13S[1][1];
          step_d    = step_in;
          samp_d[0] = box_R13S[0][0];
          samp_d[1] = box_R13S[0][1];
          state_d   = TEST;
        end
      end
      TEST: begin
        if (!stall_R14H) begin
          if (x_fit) begin
            samp_d[0] = x_sum[SIGFIG-1:0];
          end else if (y_fit) begin
            samp_d[0] = ll_q[0];
            samp_d[1] = y_sum[SIGFIG-1:0];
          end else begin
            state_d = WAIT;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT;
      tri_q   <= '{default: '0};
      color_q <= '{default: '0};
      ll_q    <= '{default: '0};
      ur_q    <= '{default: '0};
      samp_q  <= '{default: '0};
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      tri_q   <= tri_d;
      color_q <= color_d;
      ll_q    <= ll_d;
      ur_q    <= ur_d;
      samp_q  <= samp_d;
      step_q  <= step_d;
    end
  end

  assign halt_RnnnnH    = (state_q == TEST);
  assign validSamp_R14H = (state_q == TEST);
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S    = samp_q;

endmodule
